// File: rtl/line_doubler_if.sv
// Source pixel stream into the line doubler: valid/ready handshake with a
// start-of-frame qualifier on the first pixel.
interface line_doubler_if;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_data;
    logic        in_sof;

    modport master (
        output in_valid,
        output in_data,
        output in_sof,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_sof,
        output in_ready
    );
endinterface

// File: rtl/line_doubler.sv
// 2x line doubler: two ping-pong line buffers filled from a source stream,
// each source line replayed on two display rows at twice the pixel width.
module line_doubler #(
    parameter int unsigned SRCW    = 640,
    parameter int unsigned SRCH    = 360,
    parameter int unsigned DSPW    = 1280,
    parameter int unsigned DSPH    = 720,
    parameter logic [23:0] UFCOLOR = 24'h0000FF
) (
    input  logic                 clk,
    input  logic                 rst,
    line_doubler_if.slave        src,
    input  logic [10:0]          sx,
    input  logic [9:0]           sy,
    output logic [23:0]          rgb,
    output logic                 underflow,
    output logic                 sof_err
);

    localparam int unsigned XW = (SRCW > 1) ? $clog2(SRCW) : 1;
    localparam int unsigned LW = (SRCH > 1) ? $clog2(SRCH) : 1;
    localparam logic [XW-1:0] X_LAST  = XW'(SRCW - 1);
    localparam logic [LW-1:0] L_LAST  = LW'(SRCH - 1);
    localparam logic [10:0]   DSPW_L  = 11'(DSPW);
    localparam logic [10:0]   SX_LAST = 11'(DSPW - 1);
    localparam logic [9:0]    DSPH_L  = 10'(DSPH);

    typedef enum logic {SYNC, FILL} wr_state_t;

    wr_state_t     state, state_next;
    logic [XW-1:0] wr_x;
    logic [LW-1:0] wr_line;
    logic [1:0]    full;
    logic [1:0]    set_full, clr_full;

    logic          wr_buf;
    logic [XW-1:0] wr_addr;
    logic          wr_en;
    logic          line_done;
    logic          bad_sof;
    logic          xfer;

    logic [23:0]   mem0 [SRCW];
    logic [23:0]   mem1 [SRCW];
    logic [23:0]   rd0, rd1;

    logic          vis, line_start, ok_now, release_line, b;
    logic [XW-1:0] col;
    logic          line_ok, vis_q, b_q;

    // ---------------- write side ----------------
    assign wr_buf       = (state == FILL) && wr_line[0];
    assign src.in_ready = ~full[wr_buf];
    assign xfer         = src.in_valid && src.in_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= SYNC;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            SYNC: if (wr_en) state_next = FILL;
            FILL: if (bad_sof || (line_done && wr_line == L_LAST)) state_next = SYNC;
        endcase
    end

    always_comb begin
        wr_addr   = '0;
        wr_en     = 1'b0;
        line_done = 1'b0;
        bad_sof   = 1'b0;
        unique case (state)
            SYNC: wr_en = xfer && src.in_sof;
            FILL: begin
                wr_addr   = wr_x;
                wr_en     = xfer && !src.in_sof;
                line_done = wr_en && (wr_x == X_LAST);
                bad_sof   = xfer && src.in_sof;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_x    <= '0;
            wr_line <= '0;
            sof_err <= 1'b0;
        end else begin
            sof_err <= bad_sof;
            if (state == SYNC) begin
                if (wr_en) begin
                    wr_x    <= XW'(1);
                    wr_line <= '0;
                end
            end else if (bad_sof) begin
                wr_x    <= '0;
                wr_line <= '0;
            end else if (wr_en) begin
                if (line_done) begin
                    wr_x    <= '0;
                    wr_line <= (wr_line == L_LAST) ? '0 : wr_line + 1'b1;
                end else begin
                    wr_x <= wr_x + 1'b1;
                end
            end
        end
    end

    always_comb begin
        set_full = '0;
        clr_full = '0;
        if (line_done)    set_full[wr_buf] = 1'b1;
        if (release_line) clr_full[b]      = 1'b1;
    end

    // Clear wins over set for the same flag.
    always_ff @(posedge clk) begin
        if (rst) full <= '0;
        else     full <= (full | set_full) & ~clr_full;
    end

    // ---------------- line buffers ----------------
    always_ff @(posedge clk) begin
        if (wr_en && !wr_buf) mem0[wr_addr] <= src.in_data;
        if (vis)              rd0 <= mem0[col];
    end

    always_ff @(posedge clk) begin
        if (wr_en && wr_buf) mem1[wr_addr] <= src.in_data;
        if (vis)             rd1 <= mem1[col];
    end

    // ---------------- display side ----------------
    assign b            = sy[1];
    assign col          = sx[XW:1];
    assign vis          = (sx < DSPW_L) && (sy < DSPH_L);
    assign line_start   = (sx == '0) && (sy < DSPH_L);
    assign ok_now       = line_start ? full[b] : line_ok;
    assign release_line = (sx == SX_LAST) && sy[0] && (sy < DSPH_L) && ok_now;

    always_ff @(posedge clk) begin
        if (rst) begin
            line_ok   <= 1'b0;
            vis_q     <= 1'b0;
            b_q       <= 1'b0;
            underflow <= 1'b0;
        end else begin
            line_ok   <= ok_now;
            vis_q     <= vis;
            b_q       <= b;
            underflow <= line_start && !full[b];
        end
    end

    // RAM output and pixel controls are both registered, so this mux keeps a
    // single cycle of latency from sx/sy to rgb.
    always_comb begin
        rgb = '0;
        if (vis_q) rgb = line_ok ? (b_q ? rd1 : rd0) : UFCOLOR;
    end

endmodule

// File: tb/tb_line_doubler.sv
// Directed bench for line_doubler on a reduced 8x4 -> 16x8 raster with
// blanking; checkpoint tables plus hand-written corner sequences.
module tb_line_doubler;
    localparam int SW = 8;
    localparam int SH = 4;
    localparam int DW = 16;
    localparam int DH = 8;
    localparam int HT = 20;
    localparam int VT = 10;
    localparam logic [23:0] UF = 24'h0000FF;

    typedef enum int {K_RGB, K_UF, K_RDY} kind_t;
    typedef struct {
        kind_t       kind;
        int          y;
        int          x;
        logic [31:0] exp;
        string       name;
        bit          hit;
    } chk_t;
    typedef struct {
        logic [23:0] data;
        logic        sof;
    } pix_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] sx  = '0;
    logic [9:0]  sy  = '0;
    logic [23:0] rgb;
    logic        underflow;
    logic        sof_err;

    line_doubler_if src_if();

    line_doubler #(
        .SRCW(SW), .SRCH(SH), .DSPW(DW), .DSPH(DH), .UFCOLOR(UF)
    ) dut (
        .clk(clk), .rst(rst), .src(src_if), .sx(sx), .sy(sy),
        .rgb(rgb), .underflow(underflow), .sof_err(sof_err)
    );

    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_fail = 0;
    chk_t tbl[$];
    pix_t q[$];
    bit   run = 1'b0;
    int   cur_x = 0, cur_y = 0, prev_x = 0, prev_y = 0;
    int   scan = 0;
    int   scan_bad = 0;
    int   uf_cnt = 0;

    task automatic compare(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(kind_t k, int y, int x, logic [31:0] e, string n);
        chk_t c;
        c.kind = k; c.y = y; c.x = x; c.exp = e; c.name = n; c.hit = 1'b0;
        tbl.push_back(c);
    endtask

    task automatic finish_tbl();
        foreach (tbl[i]) if (!tbl[i].hit) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: checkpoint row %0d col %0d never reached", tbl[i].name, tbl[i].y, tbl[i].x);
        end
        tbl.delete();
    endtask

    task automatic step();
        bit          fire;
        logic [31:0] e;
        sx = 11'(cur_x);
        sy = 10'(cur_y);
        if (q.size() > 0) begin
            src_if.in_valid = 1'b1;
            src_if.in_data  = q[0].data;
            src_if.in_sof   = q[0].sof;
        end else begin
            src_if.in_valid = 1'b0;
            src_if.in_data  = '0;
            src_if.in_sof   = 1'b0;
        end
        @(negedge clk);
        fire = src_if.in_valid && src_if.in_ready;
        foreach (tbl[i]) if (!tbl[i].hit && tbl[i].kind == K_RDY && tbl[i].y == cur_y && tbl[i].x == cur_x) begin
            compare(tbl[i].name, 32'(src_if.in_ready), tbl[i].exp);
            tbl[i].hit = 1'b1;
        end
        @(posedge clk);
        #1;
        if (fire) void'(q.pop_front());
        prev_x = cur_x;
        prev_y = cur_y;
        if (run) begin
            if (cur_x == HT - 1) begin
                cur_x = 0;
                cur_y = (cur_y == VT - 1) ? 0 : cur_y + 1;
            end else begin
                cur_x++;
            end
        end
        if (underflow) uf_cnt++;
        foreach (tbl[i]) if (!tbl[i].hit && tbl[i].kind != K_RDY && tbl[i].y == prev_y && tbl[i].x == prev_x) begin
            if (tbl[i].kind == K_RGB) compare(tbl[i].name, 32'(rgb), tbl[i].exp);
            else                      compare(tbl[i].name, 32'(underflow), tbl[i].exp);
            tbl[i].hit = 1'b1;
        end
        if (scan != 0) begin
            e = 0;
            if (prev_x < DW && prev_y < DH)
                e = (scan == 1) ? 32'(UF) : 32'((prev_y / 2) * SW + prev_x / 2);
            if (32'(rgb) !== e) scan_bad++;
        end
    endtask

    task automatic run_steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to(int y, int x, int max);
        int k = 0;
        while (!(cur_y == y && cur_x == x) && k < max) begin
            step();
            k++;
        end
    endtask

    task automatic drain(int max, string name);
        int k = 0;
        while (q.size() > 0 && k < max) begin
            step();
            k++;
        end
        compare(name, q.size(), 0);
    endtask

    task automatic push_line(int base, int n, bit sof_first);
        pix_t p;
        for (int i = 0; i < n; i++) begin
            p.data = 24'(base + i);
            p.sof  = sof_first && (i == 0);
            q.push_back(p);
        end
    endtask

    task automatic reset_dut();
        q.delete();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        pix_t bad;

        // Reset state, then a full incrementing frame ahead of the display
        run = 1'b0; cur_y = 8; cur_x = 0;
        reset_dut();
        compare("rst_rgb", 32'(rgb), 0);
        compare("rst_underflow", 32'(underflow), 0);
        compare("rst_sof_err", 32'(sof_err), 0);
        #2 compare("rst_in_ready", 32'(src_if.in_ready), 1);

        add(K_RGB, 8, 0, 0, "vblank_first");
        add(K_RGB, 0, 0, 0, "row0_col0");
        add(K_RGB, 0, 1, 0, "row0_col1");
        add(K_RGB, 0, 2, 1, "row0_col2");
        add(K_RGB, 0, 15, 7, "row0_col15");
        add(K_RGB, 0, 16, 0, "hblank");
        add(K_RGB, 1, 15, 7, "row1_col15");
        add(K_RGB, 2, 0, 8, "row2_col0");
        add(K_RGB, 3, 5, 10, "row3_col5");
        add(K_RGB, 4, 0, 16, "line2_in_b0");
        add(K_RGB, 5, 14, 23, "row5_col14");
        add(K_RGB, 6, 3, 25, "row6_col3");
        add(K_RGB, 7, 15, 31, "row7_col15");
        add(K_UF, 0, 0, 0, "row0_no_uf");
        add(K_UF, 4, 0, 0, "row4_no_uf");
        add(K_RDY, 0, 5, 0, "ready_both_full");
        add(K_RDY, 1, 15, 0, "ready_before_release");
        add(K_RDY, 1, 16, 1, "ready_after_release");
        push_line(0, SW * SH, 1'b1);
        run = 1'b1; scan = 2; scan_bad = 0; uf_cnt = 0;
        run_steps(2 * HT + DH * HT);
        scan = 0;
        compare("frame_scan_bad", scan_bad, 0);
        compare("frame_uf_count", uf_cnt, 0);
        compare("frame_drained", q.size(), 0);
        finish_tbl();

        // No source data: every visible pixel underflows
        run = 1'b0; cur_y = 0; cur_x = 0;
        reset_dut();
        add(K_UF, 0, 0, 1, "uf_row0_pulse");
        add(K_RGB, 0, 0, 32'(UF), "uf_row0_col0");
        add(K_UF, 2, 1, 0, "uf_row2_col1_low");
        add(K_RGB, 3, 9, 32'(UF), "uf_row3_col9");
        add(K_RGB, 7, 15, 32'(UF), "uf_row7_col15");
        add(K_RGB, 8, 3, 0, "uf_vblank");
        add(K_RGB, 2, 17, 0, "uf_hblank");
        run = 1'b1; scan = 1; scan_bad = 0; uf_cnt = 0;
        run_steps(HT * VT);
        scan = 0;
        compare("uf_scan_bad", scan_bad, 0);
        compare("uf_pulse_count", uf_cnt, DH);
        finish_tbl();

        // Misplaced in_sof at source pixel (5,3)
        run = 1'b0; cur_y = 9; cur_x = 0;
        reset_dut();
        push_line(0, 2 * SW, 1'b1);
        drain(40, "e_fill_drain");
        #2 compare("e_ready_both_full", 32'(src_if.in_ready), 0);
        cur_y = 0; cur_x = 0; run = 1'b1;
        run_steps(4 * HT);
        run = 1'b0; cur_y = 9; cur_x = 0;
        push_line(16, SW, 1'b0);
        push_line(24, 5, 1'b0);
        drain(40, "e_line3_drain");
        bad.data = 24'hABCDEF;
        bad.sof  = 1'b1;
        q.push_back(bad);
        step();
        compare("e_bad_sof_accepted", q.size(), 0);
        compare("e_sof_err_pulse", 32'(sof_err), 1);
        step();
        compare("e_sof_err_single", 32'(sof_err), 0);
        #2 compare("e_ready_f0_kept", 32'(src_if.in_ready), 0);
        add(K_RGB, 0, 4, 18, "e_line2_row0");
        add(K_RGB, 1, 15, 23, "e_line2_row1");
        add(K_RGB, 2, 0, 32'(UF), "e_f1_unset_rgb");
        add(K_UF, 2, 0, 1, "e_f1_unset_uf");
        add(K_RGB, 3, 6, 32'(UF), "e_row3_uf");
        add(K_RDY, 3, 0, 1, "e_ready_after_release");
        cur_y = 0; cur_x = 0; run = 1'b1;
        run_steps(4 * HT);
        finish_tbl();
        run = 1'b0; cur_y = 9; cur_x = 0;
        push_line(100, SW, 1'b1);
        drain(20, "e_restart_drain");
        add(K_RGB, 0, 2, 101, "e_restart_line0");
        add(K_RGB, 1, 15, 107, "e_restart_row1");
        cur_y = 0; cur_x = 0; run = 1'b1;
        run_steps(2 * HT);
        finish_tbl();

        // Reset mid-frame while row 5 is being displayed
        run = 1'b0; cur_y = 8; cur_x = 0;
        reset_dut();
        push_line(0, SW * SH, 1'b1);
        run = 1'b1;
        run_to(5, 6, 400);
        q.delete();
        rst = 1'b1;
        step();
        rst = 1'b0;
        compare("f_rst_rgb", 32'(rgb), 0);
        compare("f_rst_underflow", 32'(underflow), 0);
        compare("f_rst_sof_err", 32'(sof_err), 0);
        add(K_RDY, 5, 7, 1, "f_ready_after_rst");
        add(K_RGB, 5, 7, 32'(UF), "f_rest_of_row");
        add(K_RGB, 6, 0, 32'(UF), "f_row6_col0");
        add(K_RGB, 6, 9, 32'(UF), "f_row6_col9");
        add(K_UF, 6, 0, 1, "f_row6_uf");
        add(K_UF, 6, 9, 0, "f_row6_uf_single");
        add(K_UF, 7, 0, 1, "f_row7_uf");
        uf_cnt = 0;
        run_to(8, 0, 200);
        compare("f_uf_count", uf_cnt, 2);
        finish_tbl();

        // Source stalls mid-line 1, resumes during row 3
        run = 1'b0; cur_y = 8; cur_x = 0;
        reset_dut();
        push_line(0, SW, 1'b1);
        push_line(8, 4, 1'b0);
        add(K_RGB, 0, 3, 1, "g_row0_col3");
        add(K_RGB, 1, 15, 7, "g_row1_col15");
        add(K_UF, 2, 0, 1, "g_row2_uf");
        add(K_RGB, 2, 0, 32'(UF), "g_row2_col0");
        add(K_RGB, 2, 7, 32'(UF), "g_row2_col7");
        add(K_UF, 3, 0, 1, "g_row3_uf");
        add(K_RGB, 3, 12, 32'(UF), "g_row3_col12");
        add(K_UF, 4, 0, 0, "g_row4_no_uf");
        add(K_RGB, 4, 3, 17, "g_row4_line2");
        add(K_RGB, 5, 15, 23, "g_row5_line2");
        add(K_RGB, 6, 0, 8, "g_row6_line1");
        add(K_UF, 6, 0, 0, "g_row6_no_uf");
        add(K_RGB, 7, 9, 12, "g_row7_line1");
        uf_cnt = 0;
        run = 1'b1;
        run_to(3, 2, 200);
        push_line(12, 4, 1'b0);
        push_line(16, SW, 1'b0);
        run_to(8, 0, 200);
        compare("g_uf_count", uf_cnt, 2);
        compare("g_drained", q.size(), 0);
        finish_tbl();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
